fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter ADDR_W, default 8, is the instruction memory word-address width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 redirect_en  input  1  branch/jump taken; replaces the fetch PC.
REQ-006 redirect_pc  input  32  target byte address; bits [1:0] ignored, treated as 0.
REQ-007 if_ready  input  1  decode accepts if_instr/if_pc this cycle.
REQ-008 mem_valid  input  1  memory response valid, one cycle after mem_request.
REQ-009 mem_r_data  input  32  instruction word, sampled only when mem_valid=1.
REQ-010 mem_request  output  1  fetch request to instruction memory.
REQ-011 mem_address  output  ADDR_W  word address = fetch_pc[ADDR_W+1:2].
REQ-012 mem_we_re  output  1  tied 0 (read).
REQ-013 mem_masking  output  4  tied 4'b1111.
REQ-014 if_valid  output  1  buffer head holds a valid instruction.
REQ-015 if_instr  output  32  head instruction.
REQ-016 if_pc  output  32  byte address of head instruction.

Function
REQ-017 The block SHALL hold fetch_pc, a 2-entry in-order instruction buffer (instr+pc), and an in-flight flag for the request issued last cycle.
REQ-018 mem_request SHALL be 1 in a cycle iff not in reset, redirect_en=0, and (buffer occupancy + in-flight + 0) < 2 after counting this cycle's if_valid&&if_ready pop.
REQ-019 Each cycle mem_request=1, fetch_pc SHALL advance by 4 on the next edge and the issued pc SHALL be recorded with the in-flight flag.
REQ-020 Steady state with if_ready=1 SHALL sustain one request and one delivered instruction per cycle; latency request -> if_valid is 2 cycles (response at N+1, buffer output at N+2).
REQ-021 On mem_valid=1 with in-flight set and not killed, {mem_r_data, recorded pc} SHALL be pushed to the buffer tail.
REQ-022 if_valid/if_instr/if_pc SHALL reflect buffer head; pop on if_valid&&if_ready; head values SHALL hold stable while if_valid=1 and if_ready=0.
REQ-023 Simultaneous push and pop with buffer full SHALL not occur (guaranteed by REQ-018); push and pop on a 1-entry buffer SHALL keep occupancy at 1.
REQ-024 redirect_en=1 SHALL: flush buffer (if_valid=0 next cycle), set fetch_pc to {redirect_pc[31:2],2'b00}, mark any in-flight response killed (dropped on arrival), suppress mem_request that cycle.
REQ-025 First request after redirect SHALL issue the cycle after redirect_en, at the new pc.
REQ-026 Redirect SHALL win over a same-cycle pop or push; a same-cycle if_ready handshake on the old head counts as accepted.
REQ-027 mem_valid without in-flight flag SHALL be ignored.
REQ-028 fetch_pc SHALL wrap modulo 2^32; mem_address wraps modulo 2^ADDR_W.

Reset
REQ-029 While rst=1: fetch_pc=RESET_PC, buffer empty, in-flight=0, mem_request=0, if_valid=0, if_instr=32'h0000_0013, if_pc=RESET_PC.
REQ-030 First mem_request SHALL assert in the first cycle with rst=0, at mem_address=RESET_PC[ADDR_W+1:2].
REQ-031 Reset asserted mid-operation SHALL discard in-flight responses and buffer contents immediately.

Structure
REQ-032 Package fetch_pkg SHALL hold NOP_INSTR (32'h0000_0013), DEFAULT_RESET_PC, BUF_DEPTH=2.
REQ-033 The 2-entry buffer SHALL be sub-module fetch_buf (push/pop/flush, count, head outputs).

Verification
REQ-034 Reset release, memory word k = 32'h1000_0000+k, if_ready=1 -> requests at addresses 0,1,2,... every cycle; if_valid at cycle 2 with instr 32'h1000_0000, pc 0, then pc 4, 8 each cycle.
REQ-035 if_ready=0 from cycle 3 for 5 cycles -> at most 2 buffered, mem_request low after buffer fills, head held; on release, no instruction lost or duplicated.
REQ-036 redirect_en=1 with redirect_pc=32'h0000_0043 while a request is in flight -> in-flight response dropped, next request address 16 (pc 0x40), next if_pc 0x40.
REQ-037 redirect and if_ready handshake in the same cycle -> handshaked instruction counted once, buffer empty next cycle, no stale pc delivered.
REQ-038 rst pulsed mid-stream -> outputs return to REQ-029 values asynchronously; fetch restarts at RESET_PC.
REQ-039 fetch_pc = 32'hFFFF_FFFC, ADDR_W=8 -> next issued pc 32'h0000_0000, mem_address 255 then 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, entry type and address helper for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH        = 2;
  localparam int unsigned CNT_W            = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W            = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// In-order instruction buffer between the memory response and decode.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [31:0]      head_instr,
  output logic [31:0]      head_pc
);

  localparam logic [IDX_W-1:0] HEAD = '0;

  fetch_entry_t     entry [BUF_DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] slot;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count_q != '0);
  assign slot    = count_q - CNT_W'(do_pop);
  assign do_push = push && (slot < CNT_W'(BUF_DEPTH));

  // Head always lives in entry[0]; a pop shifts down first, and the push
  // lands in the first free slot left after that shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        entry[IDX_W'(i)] <= '{instr: NOP_INSTR, pc: RESET_PC};
      end
    end else if (flush) begin
      count_q <= '0;
    end else begin
      if (do_pop) begin
        for (int unsigned i = 0; i + 1 < BUF_DEPTH; i++) begin
          entry[IDX_W'(i)] <= entry[IDX_W'(i + 1)];
        end
      end
      if (do_push) begin
        entry[IDX_W'(slot)] <= push_entry;
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_instr = entry[HEAD].instr;
  assign head_pc    = entry[HEAD].pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word reads, buffers responses, handles redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  input  logic              if_ready,
  input  logic              mem_valid,
  input  logic [31:0]       mem_r_data,
  output logic              mem_request,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we_re,
  output logic [3:0]        mem_masking,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
);

  localparam int unsigned OCC_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [CNT_W-1:0] buf_count;
  logic [OCC_W-1:0] occupancy;
  logic             pop;
  logic             push;
  fetch_entry_t     resp_entry;

  assign pop        = if_valid && if_ready;
  assign occupancy  = OCC_W'(buf_count) + OCC_W'(inflight) - OCC_W'(pop);
  assign mem_request = !rst && !redirect_en && (occupancy < OCC_W'(BUF_DEPTH));

  // A redirect never issues, so the in-flight flag clears on the same edge
  // that drops the response arriving during the redirect cycle.
  assign push       = mem_valid && inflight && !redirect_en;
  assign resp_entry = '{instr: mem_r_data, pc: inflight_pc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= mem_request;
      if (mem_request) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect_en) begin
        fetch_pc <= align_word(redirect_pc);
      end else if (mem_request) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_buf #(
    .RESET_PC(RESET_PC)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (push),
    .push_entry(resp_entry),
    .pop       (pop),
    .count     (buf_count),
    .head_valid(if_valid),
    .head_instr(if_instr),
    .head_pc   (if_pc)
  );

  assign mem_address = fetch_pc[ADDR_W+1:2];
  assign mem_we_re   = 1'b0;
  assign mem_masking = '1;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of outstanding fetches.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam int          AW        = 8;
  localparam logic [31:0] WORD_BASE = 32'h1000_0000;

  logic          clk;
  logic          rst;
  logic          redirect_en;
  logic [31:0]   redirect_pc;
  logic          if_ready;
  logic          mem_valid;
  logic [31:0]   mem_r_data;
  logic          mem_request;
  logic [AW-1:0] mem_address;
  logic          mem_we_re;
  logic [3:0]    mem_masking;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .ADDR_W  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .if_ready   (if_ready),
    .mem_valid  (mem_valid),
    .mem_r_data (mem_r_data),
    .mem_request(mem_request),
    .mem_address(mem_address),
    .mem_we_re  (mem_we_re),
    .mem_masking(mem_masking),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every fetch the model believes was issued and not yet consumed or flushed.
  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } req_t;

  req_t          outstanding[$];
  logic [31:0]   next_pc;
  int            cyc;
  int            n_tests;
  int            n_fail;
  logic          mem_pend;
  logic [AW-1:0] mem_pend_addr;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return WORD_BASE + ((pc >> 2) % (32'd1 << AW));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst.mem_request", 32'(mem_request), 32'd0);
    check("rst.if_valid", 32'(if_valid), 32'd0);
    check("rst.if_instr", if_instr, 32'h0000_0013);
    check("rst.if_pc", if_pc, RST_PC);
  endtask

  // Called just after a rising edge; that edge's cycle becomes cycle 0.
  task automatic release_reset();
    redirect_en = 1'b0;
    if_ready    = 1'b0;
    mem_valid   = 1'b0;
    outstanding.delete();
    next_pc  = RST_PC;
    mem_pend = 1'b0;
    cyc      = 0;
    rst      = 1'b0;
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    release_reset();
  endtask

  // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic run_cycle(input logic rdy, input logic redir, input logic [31:0] rpc,
                           input logic spurious);
    logic exp_valid;
    logic exp_req;
    logic pop;
    req_t r;

    if_ready    = rdy;
    redirect_en = redir;
    redirect_pc = rpc;
    if (mem_pend) begin
      mem_valid  = 1'b1;
      mem_r_data = WORD_BASE + 32'(mem_pend_addr);
    end else begin
      mem_valid  = spurious;
      mem_r_data = $urandom;
    end

    #4;
    exp_valid = (outstanding.size() > 0) && (cyc - outstanding[0].cyc >= 2);
    pop       = exp_valid && rdy;
    exp_req   = !redir && ((outstanding.size() - (pop ? 1 : 0)) < 2);

    check("mem_request", 32'(mem_request), 32'(exp_req));
    if (exp_req) check("mem_address", 32'(mem_address), 32'(next_pc[AW+1:2]));
    check("if_valid", 32'(if_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("if_pc", if_pc, outstanding[0].pc);
      check("if_instr", if_instr, word_at(outstanding[0].pc));
    end
    check("mem_we_re", 32'(mem_we_re), 32'd0);
    check("mem_masking", 32'(mem_masking), 32'hF);

    mem_pend      = mem_request;
    mem_pend_addr = mem_address;

    if (pop) void'(outstanding.pop_front());
    if (redir) begin
      outstanding.delete();
      next_pc = rpc & 32'hFFFF_FFFC;
    end else if (exp_req) begin
      r.pc  = next_pc;
      r.cyc = cyc;
      outstanding.push_back(r);
      next_pc = next_pc + 32'd4;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom,
                $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    rst         = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;
    if_ready    = 1'b0;
    mem_valid   = 1'b0;
    mem_r_data  = '0;
    mem_pend    = 1'b0;
    next_pc     = RST_PC;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    release_reset();

    // Streaming after reset, then a decode stall and release.
    repeat (12) run_cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (5) run_cycle(1'b0, 1'b0, '0, 1'b0);
    repeat (6) run_cycle(1'b1, 1'b0, '0, 1'b0);

    // Redirect with a fetch in flight, to an unaligned target.
    run_cycle(1'b1, 1'b1, 32'h0000_0043, 1'b0);
    repeat (6) run_cycle(1'b1, 1'b0, '0, 1'b0);

    // Redirect coinciding with a handshake on a valid head.
    run_cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    repeat (5) run_cycle(1'b1, 1'b0, '0, 1'b0);

    // Redirect while the buffer is full and decode is stalled.
    repeat (4) run_cycle(1'b0, 1'b0, '0, 1'b0);
    run_cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (5) run_cycle(1'b1, 1'b0, '0, 1'b1);

    // Top-of-address-space wrap.
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (6) run_cycle(1'b1, 1'b0, '0, 1'b0);

    run_random(500);

    async_reset();
    repeat (10) run_cycle(1'b1, 1'b0, '0, 1'b0);
    run_random(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
